// File: rtl/decoder.sv
// ---------------------------------------------------------------------------
// decoder -- 3-to-8 line decoder with active-high enable and optionally
// registered one-hot outputs.
//
// Parameters:
//   OUT_REG          1: outputs registered (1-cycle latency, async reset)
//                    0: outputs combinational from current inputs
//   OUT_ACTIVE_HIGH  1: selected line 1, others 0
//                    0: all lines inverted (idle/reset state all 1)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset, clears the output register
//   dcodeing   decode enable, 0 forces all lines inactive
//   input2..0  binary select, input2 is the MSB
//   out0..out7 decoded lines, outN active when enabled and select == N
// ---------------------------------------------------------------------------
module decoder #(
    parameter int OUT_REG         = 1,
    parameter int OUT_ACTIVE_HIGH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic dcodeing,
    input  logic input2,
    input  logic input1,
    input  logic input0,
    output logic out0,
    output logic out1,
    output logic out2,
    output logic out3,
    output logic out4,
    output logic out5,
    output logic out6,
    output logic out7
);

    logic [2:0] sel_p0;
    logic [7:0] dec_p0;
    logic [7:0] dec_p1;
    logic [7:0] lines;

    // Output polarity is applied after the register, so an all-zero
    // internal state always means "all lines inactive".
    function automatic logic [7:0] apply_polarity(input logic [7:0] v);
        if (OUT_ACTIVE_HIGH != 0) begin
            return v;
        end
        return ~v;
    endfunction

    // Stage p0: combinational decode of the current inputs
    assign sel_p0 = {input2, input1, input0};

    always_comb begin
        dec_p0 = '0;
        if (dcodeing) begin
            dec_p0[sel_p0] = 1'b1;
        end
    end

    // Stage p1: output register (or bypass)
    generate
        if (OUT_REG != 0) begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dec_p1 <= '0;
                end else begin
                    dec_p1 <= dec_p0;
                end
            end
        end else begin : g_comb
            assign dec_p1 = dec_p0;
        end
    endgenerate

    assign lines = apply_polarity(dec_p1);

    assign out0 = lines[0];
    assign out1 = lines[1];
    assign out2 = lines[2];
    assign out3 = lines[3];
    assign out4 = lines[4];
    assign out5 = lines[5];
    assign out6 = lines[6];
    assign out7 = lines[7];

endmodule

// File: tb/tb_decoder.sv
// ---------------------------------------------------------------------------
// tb_decoder -- self-checking bench for decoder (default parameters).
// Directed table of {enable, select, expected lines} plus hand-written
// sequences for reset, async reset mid-run and latency.
// ---------------------------------------------------------------------------
module tb_decoder;

    logic clk;
    logic rst_n;
    logic dcodeing;
    logic input2;
    logic input1;
    logic input0;
    logic out0, out1, out2, out3, out4, out5, out6, out7;
    logic [7:0] outv;

    int checks;
    int failures;

    typedef struct {
        logic       en;
        logic [2:0] sel;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    decoder #(
        .OUT_REG        (1),
        .OUT_ACTIVE_HIGH(1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .dcodeing(dcodeing),
        .input2  (input2),
        .input1  (input1),
        .input0  (input0),
        .out0    (out0),
        .out1    (out1),
        .out2    (out2),
        .out3    (out3),
        .out4    (out4),
        .out5    (out5),
        .out6    (out6),
        .out7    (out7)
    );

    assign outv = {out7, out6, out5, out4, out3, out2, out1, out0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic en, input logic [2:0] sel);
        dcodeing = en;
        input2   = sel[2];
        input1   = sel[1];
        input0   = sel[0];
    endtask

    // drive on the falling edge, sample 1 time unit after the next rising edge
    task automatic step(input logic en, input logic [2:0] sel);
        @(negedge clk);
        drive(en, sel);
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        drive(1'b1, 3'd5);

        // reset held: inputs toggle, outputs stay clear
        #2;
        check("reset_initial", outv, 8'h00);
        for (int i = 0; i < 4; i++) begin
            step(i[0], 3'(i * 3));
            check("reset_hold", outv, 8'h00);
        end

        // release with enable=1, sel=0
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 3'd0);
        @(posedge clk);
        #1;
        check("reset_release_sel0", outv, 8'h01);

        // disabled sweep
        for (int s = 0; s < 8; s++) vecs.push_back('{1'b0, 3'(s), 8'h00});
        // enabled sweep, hand-computed one-hot values
        vecs.push_back('{1'b1, 3'd0, 8'h01});
        vecs.push_back('{1'b1, 3'd1, 8'h02});
        vecs.push_back('{1'b1, 3'd2, 8'h04});
        vecs.push_back('{1'b1, 3'd3, 8'h08});
        vecs.push_back('{1'b1, 3'd4, 8'h10});
        vecs.push_back('{1'b1, 3'd5, 8'h20});
        vecs.push_back('{1'b1, 3'd6, 8'h40});
        vecs.push_back('{1'b1, 3'd7, 8'h80});
        // enable toggle with sel=3 held
        vecs.push_back('{1'b1, 3'd3, 8'h08});
        vecs.push_back('{1'b0, 3'd3, 8'h00});
        vecs.push_back('{1'b1, 3'd3, 8'h08});
        // enable and select changing together
        vecs.push_back('{1'b0, 3'd6, 8'h00});
        vecs.push_back('{1'b1, 3'd1, 8'h02});
        vecs.push_back('{1'b0, 3'd4, 8'h00});
        vecs.push_back('{1'b1, 3'd7, 8'h80});

        foreach (vecs[i]) begin
            step(vecs[i].en, vecs[i].sel);
            check($sformatf("vec%0d_en%0d_sel%0d", i, vecs[i].en, vecs[i].sel),
                  outv, vecs[i].exp);
        end

        // async reset mid-run: out6 drops before the next rising edge
        step(1'b1, 3'd6);
        check("pre_async_out6", outv, 8'h40);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_immediate", outv, 8'h00);
        @(posedge clk);
        #1;
        check("async_reset_held", outv, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("async_release_sel6", outv, 8'h40);

        // latency: sel 2 -> 7 just after an edge
        step(1'b1, 3'd2);
        check("latency_out2", outv, 8'h04);
        drive(1'b1, 3'd7);
        #3;
        check("latency_hold_out2", outv, 8'h04);
        @(posedge clk);
        #1;
        check("latency_out7", outv, 8'h80);

        // disable afterwards clears everything
        step(1'b0, 3'd7);
        check("final_disable", outv, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decoder.md
Name: decoder

Overview:
- 3-to-8 line decoder with active-high enable and registered one-hot outputs.
- Converts a 3-bit binary select (input2 = MSB, input0 = LSB) into eight individual active-high output lines.
- Used as a generic address/select decoder in the datapath wherever a one-hot strobe is derived from a binary code.
- Outputs are registered on one clock; the reset is asynchronous, active-low.

Parameters:
- OUT_REG, default 1, meaning: 1 = outputs registered (1-cycle latency); 0 = outputs purely combinational from the current inputs; the reset then has no effect on the outputs.
- OUT_ACTIVE_HIGH, default 1, meaning: 1 = selected output driven 1, others 0; 0 = all outputs inverted (selected output 0, others 1; disabled and reset state all 1).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset; clears the output register.
- dcodeing  input  1  decode enable, active-high; 0 forces all outputs inactive.
- input2  input  1  select bit 2 (MSB).
- input1  input  1  select bit 1.
- input0  input  1  select bit 0 (LSB).
- out0..out7  output  1 each  decoded lines; outN is active when enabled and {input2,input1,input0} == N.

Behaviour:
- Select index sel = 4*input2 + 2*input1 + input0, range 0..7. All 8 codes are valid; there is no out-of-range case.
- Combinational next value:
  - dcodeing=1: exactly one line active (out[sel]), the other seven inactive.
  - dcodeing=0: all eight lines inactive.
- With OUT_REG=1:
  - On rising clk edge, the register loads the combinational next value.
  - Outputs change only on the clock edge: 1-cycle latency from any input change.
- Reset (rst_n=0), asynchronous:
  - All outputs go inactive immediately, independent of clk (all 0 for OUT_ACTIVE_HIGH=1).
  - Outputs stay inactive while rst_n is low.
  - On the first rising edge after rst_n deasserts, outputs load the decode of the inputs present at that edge.
- Reset asserted mid-operation: outputs clear at once; no prior state survives.
- Enable and select changing in the same cycle: the next registered value is the decode of the new enable and the new select together. No glitch is visible on the registered outputs.
- One-hot invariant: at every clock edge outside reset, the number of active lines is 1 if dcodeing=1 at the preceding edge and 0 otherwise.
- Unknown (X/Z) input values: no defined decoding is required. The bench drives only 0/1 after reset.
- Tie-off: no other internal state, no handshake.

Test Plan:
- Reset check: hold rst_n=0, toggle clk and all inputs -> out0..out7 all 0. Deassert rst_n with dcodeing=1 and sel=0 -> after the next edge, out0=1 and the rest are 0.
- Disabled sweep: dcodeing=0, sel = 0..7 one per cycle -> all outputs 0 every cycle.
- Enabled sweep: dcodeing=1, sel = 0..7 one per cycle -> one cycle later out[sel]=1 and the other seven are 0. Example: input2=1, input1=0, input0=1 gives out5=1 only.
- Enable toggle: sel=3 held, dcodeing toggles 1,0,1 -> out3 follows as 1,0,1 with 1-cycle latency; the other lines stay 0.
- Async reset mid-run: dcodeing=1, sel=6, out6=1; pull rst_n low between clock edges -> out6 drops to 0 before the next edge.
- Latency check: change sel from 2 to 7 just after an edge -> out2 stays 1 until the next rising edge, then out7=1 and out2=0.
